pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes,
// data-memory wait handling with timeout and saturating perf counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             exmem_stall_o,
  output logic             memwb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_miss;
  logic mem_hold;
  logic load_use;
  logic lu_evt;
  logic br_evt;

  always_comb begin
    mem_miss = dmem_req_i & ~dmem_ack_i;
    mem_hold = mem_miss | (state_q == ERROR);
    load_use = idex_memread_i
             & (idex_rt_i != 5'd0)
             & ((idex_rt_i == ifid_rs_i)
              | (idex_rt_i == ifid_rt_i));
    lu_evt   = load_use & ~mem_hold;
    br_evt   = branch_taken_i & ~mem_hold & ~load_use;
  end

  always_comb begin
    pc_stall_o     = 1'b0;
    ifid_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_stall_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_stall_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    unique case (1'b1)
      mem_hold: begin
        pc_stall_o     = 1'b1;
        ifid_stall_o   = 1'b1;
        idex_stall_o   = 1'b1;
        exmem_stall_o  = 1'b1;
        memwb_bubble_o = 1'b1;
      end
      lu_evt: begin
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end
      br_evt: begin
        ifid_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Wait counter holds the number of MEM_WAIT cycles already spent.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_miss) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) state_d = ERROR;
        end
      end
      ERROR: ;
      default: state_d = RUN;
    endcase
    err_d = (state_d == ERROR);
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_stall_o && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (ifid_flush_o && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for the hazard
// priority logic plus sequences for miss, timeout, reset, saturation.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          memread;
  logic [4:0]    idex_rt, rs, rt;
  logic          br, req, ack;
  logic          pc_s, ifid_s, ifid_f, idex_s, idex_b, exmem_s, memwb_b;
  logic          err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .idex_memread_i (memread),
    .idex_rt_i      (idex_rt),
    .ifid_rs_i      (rs),
    .ifid_rt_i      (rt),
    .branch_taken_i (br),
    .dmem_req_i     (req),
    .dmem_ack_i     (ack),
    .pc_stall_o     (pc_s),
    .ifid_stall_o   (ifid_s),
    .ifid_flush_o   (ifid_f),
    .idex_stall_o   (idex_s),
    .idex_bubble_o  (idex_b),
    .exmem_stall_o  (exmem_s),
    .memwb_bubble_o (memwb_b),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc, ifid_stall, flush, idex_stall, bubble, exmem_stall, memwb_bubble}
  assign outs = {pc_s, ifid_s, ifid_f, idex_s, idex_b, exmem_s, memwb_b};

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_BR   = 7'b0010000;
  localparam logic [6:0] O_MEM  = 7'b1101011;

  typedef struct {
    string      nm;
    logic       mr;
    logic [4:0] irt, rs, rt;
    logic       br, req, ack;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    memread = 1'b0; idex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
    br = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{"idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NONE};
    tbl[1]  = '{"lu_rs",       1, 5'd5, 5'd5, 5'd1, 0, 0, 0, O_LU};
    tbl[2]  = '{"lu_rt",       1, 5'd5, 5'd3, 5'd5, 0, 0, 0, O_LU};
    tbl[3]  = '{"lu_zero",     1, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NONE};
    tbl[4]  = '{"no_memread",  0, 5'd5, 5'd5, 5'd5, 0, 0, 0, O_NONE};
    tbl[5]  = '{"lu_nomatch",  1, 5'd7, 5'd3, 5'd4, 0, 0, 0, O_NONE};
    tbl[6]  = '{"branch",      0, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_BR};
    tbl[7]  = '{"lu_over_br",  1, 5'd9, 5'd2, 5'd9, 1, 0, 0, O_LU};
    tbl[8]  = '{"req_ack",     0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_NONE};
    tbl[9]  = '{"mem_prio",    1, 5'd5, 5'd5, 5'd0, 1, 1, 0, O_MEM};
    tbl[10] = '{"wait_ack",    1, 5'd5, 5'd5, 5'd0, 1, 1, 1, O_LU};
    tbl[11] = '{"br_after",    0, 5'd0, 5'd0, 5'd0, 1, 0, 1, O_BR};

    idle_in();
    rst_n = 1'b0;
    #1;
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      memread = tbl[i].mr;  idex_rt = tbl[i].irt;
      rs = tbl[i].rs;       rt = tbl[i].rt;
      br = tbl[i].br;       req = tbl[i].req;
      ack = tbl[i].ack;
      #1;
      chk(tbl[i].nm, 32'(outs), 32'(tbl[i].exp));
    end

    // Single load-use cycle
    do_reset();
    memread = 1'b1; idex_rt = 5'd5; rs = 5'd5;
    #1;
    chk("lu1_outs", 32'(outs), 32'(O_LU));
    @(negedge clk);
    idle_in();
    #1;
    chk("lu1_after", 32'(outs), 32'(O_NONE));
    chk("lu1_cnt", 32'(stall_cnt), 32'd1);

    // r0 never creates a hazard
    do_reset();
    memread = 1'b1; idex_rt = 5'd0; rs = 5'd0;
    @(negedge clk);
    #1;
    chk("zero_outs", 32'(outs), 32'(O_NONE));
    chk("zero_cnt", 32'(stall_cnt), 32'd0);

    // Miss acknowledged after three hold cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      req = 1'b1; ack = 1'b0;
      #1;
      chk($sformatf("miss_hold%0d", k), 32'(outs), 32'(O_MEM));
    end
    @(negedge clk);
    ack = 1'b1;
    #1;
    chk("miss_ack_outs", 32'(outs), 32'(O_NONE));
    @(negedge clk);
    idle_in();
    #1;
    chk("miss_cnt", 32'(stall_cnt), 32'd3);
    chk("miss_err", 32'(err), 32'd0);

    // Timeout: error after four MEM_WAIT cycles
    do_reset();
    req = 1'b1; ack = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("to_err_e%0d", k), 32'(err), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("to_cnt", 32'(stall_cnt), 32'd5);
    @(negedge clk);
    req = 1'b0; br = 1'b1;
    #1;
    chk("err_hold_outs", 32'(outs), 32'(O_MEM));
    repeat (12) @(negedge clk);
    #1;
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_cnt_sat", 32'(stall_cnt), 32'd15);
    chk("err_no_flush", 32'(flush_cnt), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_scnt", 32'(stall_cnt), 32'd0);
    chk("async_rst_outs", 32'(outs), 32'(O_BR));
    @(posedge clk);
    #1;
    chk("rst_no_count", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    br = 1'b0;

    // Reset in the middle of MEM_WAIT
    do_reset();
    req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    req = 1'b0;
    #1;
    chk("rst_mw_outs", 32'(outs), 32'(O_NONE));
    chk("rst_mw_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mw_fresh_wait", 32'(err), 32'd0);

    // Flush counter saturation
    do_reset();
    br = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    chk("flush_cnt14", 32'(flush_cnt), 32'd14);
    repeat (6) @(negedge clk);
    #1;
    chk("flush_cnt_sat", 32'(flush_cnt), 32'd15);
    chk("flush_still_on", 32'(ifid_f), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
